// File: rtl/mandel_pkg.sv
// Shared types and fixed-point helpers for the Mandelbrot iteration sequencer.
package mandel_pkg;

  localparam int MANDEL_BITS = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_P_XX,
    ST_P_YY,
    ST_P_XY,
    ST_DONE
  } state_t;

  // Product width: operands are Q3.(b-3), products are kept as Q6.(b-2).
  function automatic int prod_w(input int bits);
    return bits + 4;
  endfunction

  // Width used for sums and z updates so that nothing wraps before clamping.
  function automatic int sum_w(input int bits);
    return bits + 5;
  endfunction

  // 4.0 expressed in the product format.
  function automatic longint esc_thresh(input int bits);
    return longint'(1) << bits;
  endfunction

  // Clamp limits for z in Q3.(b-3): [-4, 4 - lsb].
  function automatic longint clamp_hi(input int bits);
    return (longint'(1) << (bits - 1)) - 1;
  endfunction

  function automatic longint clamp_lo(input int bits);
    return -(longint'(1) << (bits - 1));
  endfunction

  localparam longint ESC_THRESH = esc_thresh(MANDEL_BITS);

endpackage

// File: rtl/mandel_iter_sched_mul.sv
// Combinational signed multiplier; the product is truncated to Q6.(BITS-2).
module approx_mul
  import mandel_pkg::*;
#(
  parameter int BITS = 16
) (
  input  logic signed [BITS-1:0] a,
  input  logic signed [BITS-1:0] b,
  output logic signed [BITS+3:0] p
);

  localparam int PW = prod_w(BITS);

  logic signed [2*BITS-1:0] full;

  assign full = a * b;
  // Drop BITS-4 fractional bits by arithmetic shift (floor truncation).
  assign p = PW'(full >>> (BITS - 4));

endmodule

// File: rtl/mandel_iter_sched.sv
// Evaluates one Mandelbrot point, sharing a single multiplier across
// x*x, y*y and x*y, with escape detection and z saturation.
//
//  state   | meaning
//  --------+-----------------------------------------------
//  IDLE    | waiting for a c-value; in_ready high
//  P_XX    | x*x registered into xx
//  P_YY    | y*y registered into yy
//  P_XY    | x*y formed, escape check, z update or finish
//  DONE    | result held until out_ready
module mandel_iter_sched
  import mandel_pkg::*;
#(
  parameter int BITS      = 16,
  parameter int ITER_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BITS-1:0]      cr,
  input  logic [BITS-1:0]      ci,
  input  logic [ITER_BITS-1:0] max_iter,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ITER_BITS-1:0] out_iter,
  output logic                 out_escaped
);

  localparam int PW = prod_w(BITS);
  localparam int SW = sum_w(BITS);
  localparam logic signed [SW-1:0] THRESH = SW'(esc_thresh(BITS));
  localparam logic signed [SW-1:0] CL_HI  = SW'(clamp_hi(BITS));
  localparam logic signed [SW-1:0] CL_LO  = SW'(clamp_lo(BITS));
  localparam logic signed [BITS-1:0] Q_HI = BITS'(clamp_hi(BITS));
  localparam logic signed [BITS-1:0] Q_LO = BITS'(clamp_lo(BITS));

  state_t state, state_nxt;

  logic signed [BITS-1:0] x, y, cr_q, ci_q;
  logic signed [BITS-1:0] mul_a, mul_b, x_nxt, y_nxt;
  logic signed [PW-1:0]   xx, yy, prod;
  logic signed [SW-1:0]   xx_e, yy_e, prod_e, cr_e, ci_e;
  logic signed [SW-1:0]   mag, diff, x_raw, y_raw;
  logic [ITER_BITS-1:0]   iter, lim_q, lim_in;
  logic [ITER_BITS:0]     iter_inc;
  logic                   escape, at_limit;

  approx_mul #(.BITS(BITS)) u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (prod)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid) state_nxt = ST_P_XX;
      ST_P_XX: state_nxt = ST_P_YY;
      ST_P_YY: state_nxt = ST_P_XY;
      ST_P_XY: state_nxt = (escape || at_limit) ? ST_DONE : ST_P_XX;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs and multiplier operand selection.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mul_a     = x;
    mul_b     = y;
    case (state)
      ST_IDLE: in_ready = 1'b1;
      ST_P_XX: mul_b = x;
      ST_P_YY: mul_a = y;
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  // Escape test and z update, all in SW bits so nothing wraps before the clamp.
  always_comb begin
    xx_e   = {{(SW-PW){xx[PW-1]}}, xx};
    yy_e   = {{(SW-PW){yy[PW-1]}}, yy};
    prod_e = {{(SW-PW){prod[PW-1]}}, prod};
    cr_e   = {{(SW-BITS){cr_q[BITS-1]}}, cr_q};
    ci_e   = {{(SW-BITS){ci_q[BITS-1]}}, ci_q};
    mag    = xx_e + yy_e;
    escape = mag > THRESH;
    diff   = xx_e - yy_e;
    // Shifting by one moves from BITS-2 to BITS-3 fractional bits.
    x_raw  = (diff >>> 1) + cr_e;
    // xy raw read with one less fractional bit is exactly 2xy.
    y_raw  = prod_e + ci_e;
    if (x_raw > CL_HI)      x_nxt = Q_HI;
    else if (x_raw < CL_LO) x_nxt = Q_LO;
    else                    x_nxt = x_raw[BITS-1:0];
    if (y_raw > CL_HI)      y_nxt = Q_HI;
    else if (y_raw < CL_LO) y_nxt = Q_LO;
    else                    y_nxt = y_raw[BITS-1:0];
    iter_inc = {1'b0, iter} + 1'b1;
    at_limit = iter_inc == {1'b0, lim_q};
    lim_in   = (max_iter == '0) ? ITER_BITS'(1) : max_iter;
  end

  // Job capture, product registers, z state and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr_q        <= '0;
      ci_q        <= '0;
      lim_q       <= '0;
      x           <= '0;
      y           <= '0;
      xx          <= '0;
      yy          <= '0;
      iter        <= '0;
      out_iter    <= '0;
      out_escaped <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          cr_q  <= cr;
          ci_q  <= ci;
          lim_q <= lim_in;
          x     <= '0;
          y     <= '0;
          iter  <= '0;
        end
        ST_P_XX: xx <= prod;
        ST_P_YY: yy <= prod;
        ST_P_XY: begin
          if (escape) begin
            out_iter    <= iter;
            out_escaped <= 1'b1;
          end else begin
            x    <= x_nxt;
            y    <= y_nxt;
            iter <= iter_inc[ITER_BITS-1:0];
            if (at_limit) begin
              out_iter    <= lim_q;
              out_escaped <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
